// File: rtl/csa_pkg.sv
// Shared defaults and state encoding for the carry-save resolver.
// NSLICE is the number of SLICE-bit chunks needed to cover the WIDTH+2 result.
package csa_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int SLICE_DEF  = 4;
    localparam int NSLICE_DEF = (WIDTH_DEF + 2 + SLICE_DEF - 1) / SLICE_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/csa_slice_add.sv
// Combinational W-bit ripple-carry adder used to resolve one slice per clock.
module csa_slice_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[W];
    end

endmodule

// File: rtl/csa_resolver.sv
// Converts a carry-save pair (sum, carry) into binary sum + 2*carry, resolving
// SLICE result bits per clock through a single shared ripple adder.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] result,
    output logic             busy
);

    localparam int RW     = WIDTH + 2;
    localparam int NSLICE = (RW + SLICE - 1) / SLICE;
    localparam int PW     = NSLICE * SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t         state_q, state_d;
    logic [RW-1:0]  sum_q, sum_d;
    logic [RW-1:0]  carry_q, carry_d;
    logic [RW-1:0]  result_q, result_d;
    logic           cbit_q, cbit_d;
    logic [IW-1:0]  idx_q, idx_d;

    logic             accept;
    logic [SLICE-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;
    logic [RW-1:0]    slice_mask;
    int               shamt;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RESOLVE) || (state_q == ST_DONE);
    assign result    = result_q;

    // Operands are zero-padded to PW so the top partial slice reads zeros.
    always_comb begin
        shamt      = int'(idx_q) * SLICE;
        slice_a    = SLICE'(PW'(sum_q) >> shamt);
        slice_b    = SLICE'(PW'(carry_q) >> shamt);
        slice_mask = RW'(PW'({SLICE{1'b1}}) << shamt);
    end

    csa_slice_add #(
        .W (SLICE)
    ) u_slice_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (cbit_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        result_d = result_q;
        cbit_d   = cbit_q;
        idx_d    = idx_q;

        case (state_q)
            ST_RESOLVE: begin
                result_d = (result_q & ~slice_mask) | RW'(PW'(slice_sum) << shamt);
                cbit_d   = slice_cout;
                if (idx_q == IW'(NSLICE - 1)) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // Accept also covers DONE+out_ready, giving back-to-back with no bubble.
        if (accept) begin
            sum_d   = {2'b00, in_sum};
            carry_d = {1'b0, in_carry, 1'b0};
            cbit_d  = 1'b0;
            idx_d   = '0;
            state_d = ST_RESOLVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
            cbit_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cbit_q   <= cbit_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed self-checking bench for csa_resolver: inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_csa_resolver;

    localparam int WIDTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_sum;
    logic [WIDTH-1:0]  in_carry;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH+1:0]  result;
    logic              busy;

    int pass_count = 0;
    int total      = 0;

    csa_resolver #(
        .WIDTH (WIDTH),
        .SLICE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Presents one pair across a rising edge; returns at the following falling edge.
    task automatic offer(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts rising edges until out_valid appears; -1 if it never does.
    task automatic wait_valid(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_sum = '0;
        in_carry = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, busy} !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", {out_valid, busy});
        else pass_count++;
        total++;
        if (result !== 18'h0) $display("[TB] FAIL reset_result: got %h expected 00000", result);
        else pass_count++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_count++;
    endtask

    task automatic test_zero();
        int lat;
        offer(16'h0000, 16'h0000);
        total++;
        if (busy !== 1'b1) $display("[TB] FAIL zero_busy: got %b expected 1", busy);
        else pass_count++;
        wait_valid(lat);
        total++;
        if (lat !== 5) $display("[TB] FAIL zero_latency: got %0d expected 5", lat);
        else pass_count++;
        total++;
        if (result !== 18'h00000) $display("[TB] FAIL zero_result: got %h expected 00000", result);
        else pass_count++;
        consume();
        total++;
        if ({out_valid, busy, in_ready} !== 3'b001) $display("[TB] FAIL zero_idle: got %b expected 001", {out_valid, busy, in_ready});
        else pass_count++;
    endtask

    task automatic test_all_ones();
        int lat;
        offer(16'hFFFF, 16'hFFFF);
        wait_valid(lat);
        total++;
        if (lat !== 5) $display("[TB] FAIL ones_latency: got %0d expected 5", lat);
        else pass_count++;
        total++;
        if (result !== 18'h2FFFD) $display("[TB] FAIL ones_result: got %h expected 2fffd", result);
        else pass_count++;
        consume();
    endtask

    task automatic test_ripple();
        int lat;
        offer(16'hFFFF, 16'h0001);
        wait_valid(lat);
        total++;
        if (result !== 18'h10001) $display("[TB] FAIL ripple_result: got %h expected 10001", result);
        else pass_count++;
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad_ready;
        offer(16'h000F, 16'h0001);
        // A competing pair held during RESOLVE must be ignored.
        in_valid  = 1'b1;
        in_sum    = 16'hAAAA;
        in_carry  = 16'h5555;
        bad_ready = 0;
        for (int n = 1; n <= 20; n++) begin
            if (in_ready !== 1'b0) bad_ready++;
            @(negedge clk);
            if (out_valid) break;
        end
        in_valid = 1'b0;
        lat = out_valid ? 1 : 0;
        total++;
        if (lat !== 1) $display("[TB] FAIL bp_valid: got %0d expected 1", lat);
        else pass_count++;
        total++;
        if (bad_ready !== 0) $display("[TB] FAIL bp_ready_resolve: got %0d high cycles expected 0", bad_ready);
        else pass_count++;
        total++;
        if (result !== 18'h00011) $display("[TB] FAIL bp_result: got %h expected 00011", result);
        else pass_count++;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready} !== 2'b10 || result !== 18'h00011)
                $display("[TB] FAIL bp_hold%0d: got v/r=%b result=%h expected 10 00011", n, {out_valid, in_ready}, result);
            else pass_count++;
        end
        consume();
        total++;
        if (out_valid !== 1'b0) $display("[TB] FAIL bp_release: got %b expected 0", out_valid);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        int lat;
        offer(16'h0003, 16'h0002);
        wait_valid(lat);
        total++;
        if (result !== 18'h00007) $display("[TB] FAIL b2b_first: got %h expected 00007", result);
        else pass_count++;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = 16'h1234;
        in_carry  = 16'h0100;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready);
        else pass_count++;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if ({out_valid, busy} !== 2'b01) $display("[TB] FAIL b2b_accepted: got %b expected 01", {out_valid, busy});
        else pass_count++;
        wait_valid(lat);
        total++;
        if (lat !== 5) $display("[TB] FAIL b2b_latency: got %0d expected 5", lat);
        else pass_count++;
        total++;
        if (result !== 18'h01434) $display("[TB] FAIL b2b_result: got %h expected 01434", result);
        else pass_count++;
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        offer(16'h00AA, 16'h0055);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sum   = 16'h7777;
        in_carry = 16'h1111;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({out_valid, busy} !== 2'b00 || result !== 18'h0)
            $display("[TB] FAIL rstmid_outputs: got v/b=%b result=%h expected 00 00000", {out_valid, busy}, result);
        else pass_count++;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        total++;
        if (seen !== 0) $display("[TB] FAIL rstmid_quiet: got %0d active cycles expected 0", seen);
        else pass_count++;
        offer(16'h0100, 16'h0080);
        wait_valid(lat);
        total++;
        if (lat !== 5) $display("[TB] FAIL rstmid_latency: got %0d expected 5", lat);
        else pass_count++;
        total++;
        if (result !== 18'h00200) $display("[TB] FAIL rstmid_result: got %h expected 00200", result);
        else pass_count++;
        consume();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_all_ones();
        test_ripple();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, total);
        $finish;
    end

endmodule
